// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 sizes, response error codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_FAULT    = 2'b10;
    localparam logic [1:0] LSU_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store shift/mask, load extract and
// extend, plus size legality and alignment checks.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata_shifted,
    output logic [XLEN/8-1:0] wmask,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned,
    output logic              illegal
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    logic [LW-1:0]   lane;
    logic [7:0]      mbase;
    logic [XLEN-1:0] wtrunc;
    logic [XLEN-1:0] rsh;

    assign lane = addr_lo[LW-1:0];

    // size checks, store truncation/shift and mask
    always_comb begin
        illegal = (funct3 == 3'b111) ||
                  (XLEN == 32 && (funct3 == F3_D || funct3 == F3_WU));
        misaligned = 1'b0;
        mbase = 8'h00;
        wtrunc = '0;
        unique case (funct3[1:0])
            2'b00: begin
                mbase = 8'h01;
                wtrunc = XLEN'(wdata[7:0]);
            end
            2'b01: begin
                misaligned = addr_lo[0];
                mbase = 8'h03;
                wtrunc = XLEN'(wdata[15:0]);
            end
            2'b10: begin
                misaligned = |addr_lo[1:0];
                mbase = 8'h0F;
                wtrunc = XLEN'(wdata[31:0]);
            end
            default: begin
                misaligned = |addr_lo;
                mbase = 8'hFF;
                wtrunc = wdata;
            end
        endcase
        wmask = NB'(mbase) << lane;
        wdata_shifted = wtrunc << {lane, 3'b000};
    end

    // load lane extraction and sign/zero extension
    always_comb begin
        rsh = rdata >> {lane, 3'b000};
        unique case (funct3)
            F3_B:    rdata_ext = XLEN'($signed(rsh[7:0]));
            F3_H:    rdata_ext = XLEN'($signed(rsh[15:0]));
            F3_W:    rdata_ext = XLEN'($signed(rsh[31:0]));
            F3_BU:   rdata_ext = XLEN'(rsh[7:0]);
            F3_HU:   rdata_ext = XLEN'(rsh[15:0]);
            F3_WU:   rdata_ext = XLEN'(rsh[31:0]);
            default: rdata_ext = rsh;
        endcase
    end

endmodule

// File: rtl/lsu_pipe.sv
// Multi-cycle load/store unit: execute-side handshake in,
// valid/ready memory bus, writeback handshake out.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_we,
    output logic [1:0]        resp_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wmask,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    localparam int NB = XLEN / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e state, state_n;

    logic [2:0]      q_funct3;
    logic [2:0]      q_addr_lo;
    logic            q_we;
    logic [4:0]      q_rd;
    logic [CW-1:0]   cnt;

    logic            take, finish;
    logic [1:0]      err_n;
    logic [XLEN-1:0] rdata_n;

    logic [2:0]      a_funct3, a_addr_lo;
    logic [XLEN-1:0] a_wdata, a_rdata;
    logic [NB-1:0]   a_wmask;
    logic            a_mis, a_ill;

    // checks use the live request in IDLE, latched fields after
    assign a_funct3  = (state == S_IDLE) ? req_funct3 : q_funct3;
    assign a_addr_lo = (state == S_IDLE) ? req_addr[2:0] : q_addr_lo;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3        (a_funct3),
        .addr_lo       (a_addr_lo),
        .wdata         (req_wdata),
        .rdata         (bus_rsp_rdata),
        .wdata_shifted (a_wdata),
        .wmask         (a_wmask),
        .rdata_ext     (a_rdata),
        .misaligned    (a_mis),
        .illegal       (a_ill)
    );

    // next state and per-cycle control decisions
    always_comb begin
        state_n = state;
        take = 1'b0;
        finish = 1'b0;
        err_n = LSU_OK;
        rdata_n = '0;
        unique case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    take = 1'b1;
                    if (a_ill) begin
                        state_n = S_RESP;
                        finish = 1'b1;
                        err_n = LSU_ILLEGAL;
                    end else if (a_mis) begin
                        state_n = S_RESP;
                        finish = 1'b1;
                        err_n = LSU_MISALIGN;
                    end else begin
                        state_n = S_BUS_REQ;
                    end
                end
            end
            S_BUS_REQ: begin
                if (bus_req_ready) state_n = S_BUS_WAIT;
            end
            S_BUS_WAIT: begin
                if (bus_rsp_valid) begin
                    state_n = S_RESP;
                    finish = 1'b1;
                    err_n = bus_rsp_err ? LSU_FAULT : LSU_OK;
                    if (!q_we && !bus_rsp_err) rdata_n = a_rdata;
                end else if (TIMEOUT != 0 &&
                             cnt == CW'(TIMEOUT - 1)) begin
                    state_n = S_RESP;
                    finish = 1'b1;
                    err_n = LSU_FAULT;
                end
            end
            default: begin
                if (resp_ready) state_n = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // registered outputs, latched request fields and timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready     <= 1'b1;
            bus_req_valid <= 1'b0;
            resp_valid    <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wmask     <= '0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            resp_we       <= 1'b0;
            resp_err      <= LSU_OK;
            q_funct3      <= '0;
            q_addr_lo     <= '0;
            q_we          <= 1'b0;
            q_rd          <= '0;
            cnt           <= '0;
        end else begin
            req_ready     <= (state_n == S_IDLE);
            bus_req_valid <= (state_n == S_BUS_REQ);
            resp_valid    <= (state_n == S_RESP);
            cnt <= (state == S_BUS_WAIT) ? cnt + 1'b1 : '0;
            if (take) begin
                q_funct3  <= req_funct3;
                q_addr_lo <= req_addr[2:0];
                q_we      <= req_we;
                q_rd      <= req_rd;
                bus_we    <= req_we;
                bus_addr  <= req_addr & ~ADDR_W'(NB - 1);
                bus_wdata <= req_we ? a_wdata : '0;
                bus_wmask <= req_we ? a_wmask : '0;
            end
            if (finish) begin
                resp_err   <= err_n;
                resp_rdata <= rdata_n;
                resp_rd    <= take ? req_rd : q_rd;
                resp_we    <= take ? req_we : q_we;
            end
        end
    end

endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: XLEN=32 and XLEN=64 units
// (TIMEOUT=4) sharing stimulus, selected by sel.
module tb_lsu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_ready = 1'b0;
    logic        bus_req_ready = 1'b0;
    logic        bus_rsp_valid = 1'b0;
    logic [63:0] bus_rsp_rdata = '0;
    logic        bus_rsp_err = 1'b0;

    logic        a_rr, a_rv, a_rwe, a_bv, a_bwe;
    logic [31:0] a_rdata, a_baddr, a_bwdata;
    logic [4:0]  a_rd;
    logic [1:0]  a_err;
    logic [3:0]  a_wm;
    logic        b_rr, b_rv, b_rwe, b_bv, b_bwe;
    logic [63:0] b_rdata, b_bwdata;
    logic [31:0] b_baddr;
    logic [4:0]  b_rd;
    logic [1:0]  b_err;
    logic [7:0]  b_wm;

    logic        m_req_ready, m_resp_valid, m_resp_we;
    logic        m_bus_req_valid, m_bus_we;
    logic [63:0] m_resp_rdata, m_bus_wdata;
    logic [31:0] m_bus_addr;
    logic [4:0]  m_resp_rd;
    logic [1:0]  m_resp_err;
    logic [7:0]  m_bus_wmask;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bus_cnt = 0;
    int t_acc = 0;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_pipe #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_rr),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .req_rd(req_rd),
        .resp_valid(a_rv), .resp_ready(resp_ready),
        .resp_rdata(a_rdata), .resp_rd(a_rd),
        .resp_we(a_rwe), .resp_err(a_err),
        .bus_req_valid(a_bv), .bus_req_ready(bus_req_ready),
        .bus_we(a_bwe), .bus_addr(a_baddr),
        .bus_wdata(a_bwdata), .bus_wmask(a_wm),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata[31:0]),
        .bus_rsp_err(bus_rsp_err)
    );

    lsu_pipe #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_rr),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .resp_valid(b_rv), .resp_ready(resp_ready),
        .resp_rdata(b_rdata), .resp_rd(b_rd),
        .resp_we(b_rwe), .resp_err(b_err),
        .bus_req_valid(b_bv), .bus_req_ready(bus_req_ready),
        .bus_we(b_bwe), .bus_addr(b_baddr),
        .bus_wdata(b_bwdata), .bus_wmask(b_wm),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err(bus_rsp_err)
    );

    assign m_req_ready     = sel ? b_rr : a_rr;
    assign m_resp_valid    = sel ? b_rv : a_rv;
    assign m_resp_we       = sel ? b_rwe : a_rwe;
    assign m_resp_rdata    = sel ? b_rdata : {32'b0, a_rdata};
    assign m_resp_rd       = sel ? b_rd : a_rd;
    assign m_resp_err      = sel ? b_err : a_err;
    assign m_bus_req_valid = sel ? b_bv : a_bv;
    assign m_bus_we        = sel ? b_bwe : a_bwe;
    assign m_bus_addr      = sel ? b_baddr : a_baddr;
    assign m_bus_wdata     = sel ? b_bwdata : {32'b0, a_bwdata};
    assign m_bus_wmask     = sel ? b_wm : {4'b0, a_wm};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_bus_req_valid) bus_cnt <= bus_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [4:0] rd, input logic [63:0] er,
                        input logic [1:0] ee, input int lat);
        int n = 0;
        while (!m_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", m_req_ready, 1);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        req_rd = rd;
        sb.push_back('{er, rd, we, ee, lat});
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_taken", m_req_ready, 0);
    endtask

    task automatic bus(input int rdy_wait, input int rsp_dly,
                       input logic [63:0] rdat, input logic err,
                       input logic [31:0] ea, input logic [7:0] em,
                       input logic [63:0] ew, input logic ewe);
        int n = 0;
        while (!m_bus_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bus_req_valid", m_bus_req_valid, 1);
        chk("bus_addr", m_bus_addr, ea);
        chk("bus_wmask", m_bus_wmask, em);
        chk("bus_wdata", m_bus_wdata, ew);
        chk("bus_we", m_bus_we, ewe);
        for (int i = 0; i < rdy_wait; i++) begin
            @(negedge clk);
            chk("bus_hold_valid", m_bus_req_valid, 1);
            chk("bus_hold_addr", m_bus_addr, ea);
            chk("bus_hold_wdata", m_bus_wdata, ew);
            chk("bus_hold_wmask", m_bus_wmask, em);
            chk("req_ready_busy", m_req_ready, 0);
        end
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        chk("bus_req_drop", m_bus_req_valid, 0);
        if (rsp_dly > 0) begin
            repeat (rsp_dly - 1) @(negedge clk);
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = rdat;
            bus_rsp_err = err;
            @(negedge clk);
            bus_rsp_valid = 1'b0;
            bus_rsp_rdata = '0;
            bus_rsp_err = 1'b0;
        end
    endtask

    task automatic collect(input int stall);
        exp_t e;
        int n = 0;
        while (!m_resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid", m_resp_valid, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.lat >= 0) chk("latency", cyc - t_acc, e.lat);
        chk("resp_rdata", m_resp_rdata, e.rdata);
        chk("resp_rd", m_resp_rd, e.rd);
        chk("resp_we", m_resp_we, e.we);
        chk("resp_err", m_resp_err, e.err);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("resp_hold_valid", m_resp_valid, 1);
            chk("resp_hold_rdata", m_resp_rdata, e.rdata);
            chk("resp_hold_err", m_resp_err, e.err);
            chk("resp_hold_rd", m_resp_rd, e.rd);
            chk("req_ready_busy", m_req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("req_ready_after", m_req_ready, 1);
        chk("resp_valid_drop", m_resp_valid, 0);
    endtask

    initial begin
        int b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", m_req_ready, 1);
        chk("rst_resp_valid", m_resp_valid, 0);
        chk("rst_bus_valid", m_bus_req_valid, 0);
        chk("rst_resp_err", m_resp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", m_req_ready, 1);
        chk("idle_bus_wmask", m_bus_wmask, 0);

        // XLEN=32 byte store, highest lane
        send(1, 3'b000, 32'h80000003, 64'hA5, 5'd3, 0, 2'b00, 3);
        bus(0, 1, 0, 0, 32'h80000000, 8'h08, 64'hA5000000, 1);
        collect(0);
        // halfword store to upper half
        send(1, 3'b001, 32'h80000002, 64'hDEADBEEF, 5'd4, 0, 2'b00, 3);
        bus(0, 1, 0, 0, 32'h80000000, 8'h0C, 64'hBEEF0000, 1);
        collect(0);
        // loads with sign/zero extension
        send(0, 3'b000, 32'h80000002, 0, 5'd5, 64'hFFFFFFF0, 2'b00, 3);
        bus(0, 1, 64'h12F03456, 0, 32'h80000000, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b100, 32'h80000002, 0, 5'd6, 64'h000000F0, 2'b00, 3);
        bus(0, 1, 64'h12F03456, 0, 32'h80000000, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b101, 32'h80000002, 0, 5'd7, 64'h000012F0, 2'b00, 3);
        bus(0, 1, 64'h12F03456, 0, 32'h80000000, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b001, 32'h80000004, 0, 5'd8, 64'hFFFF8001, 2'b00, 3);
        bus(0, 1, 64'h00008001, 0, 32'h80000004, 8'h00, 0, 0);
        collect(0);

        // misaligned and illegal: no bus traffic
        b0 = bus_cnt;
        send(0, 3'b010, 32'h80000006, 0, 5'd9, 0, 2'b01, 1);
        collect(0);
        send(0, 3'b001, 32'h80000001, 0, 5'd10, 0, 2'b01, 1);
        collect(0);
        send(0, 3'b011, 32'h80000000, 0, 5'd11, 0, 2'b11, 1);
        collect(0);
        send(0, 3'b110, 32'h80000000, 0, 5'd12, 0, 2'b11, 1);
        collect(0);
        send(1, 3'b111, 32'h80000000, 0, 5'd13, 0, 2'b11, 1);
        collect(0);
        send(0, 3'b011, 32'h80000003, 0, 5'd14, 0, 2'b11, 1);
        collect(0);
        chk("no_bus_traffic", bus_cnt - b0, 0);

        // stalls on both handshakes
        send(1, 3'b010, 32'h80000010, 64'h11223344, 5'd15, 0, 2'b00, -1);
        bus(5, 3, 0, 0, 32'h80000010, 8'h0F, 64'h11223344, 1);
        collect(2);

        // timeout and bus error
        send(0, 3'b010, 32'h80000020, 0, 5'd16, 0, 2'b10, 6);
        bus(0, 0, 0, 0, 32'h80000020, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b010, 32'h80000024, 0, 5'd17, 0, 2'b10, 3);
        bus(0, 1, 64'hDEADBEEF, 1, 32'h80000024, 8'h00, 0, 0);
        collect(0);

        // XLEN=64 unit
        sel = 1'b1;
        @(negedge clk);
        send(0, 3'b011, 32'h8, 0, 5'd18,
             64'h0123456789ABCDEF, 2'b00, 3);
        bus(0, 1, 64'h0123456789ABCDEF, 0, 32'h8, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b110, 32'hC, 0, 5'd19,
             64'h0000000080000000, 2'b00, 3);
        bus(0, 1, 64'h8000000000000001, 0, 32'h8, 8'h00, 0, 0);
        collect(0);
        send(0, 3'b010, 32'hC, 0, 5'd20,
             64'hFFFFFFFF80000000, 2'b00, 3);
        bus(0, 1, 64'h8000000000000001, 0, 32'h8, 8'h00, 0, 0);
        collect(0);
        send(1, 3'b011, 32'h8, 64'h1122334455667788, 5'd21,
             0, 2'b00, 3);
        bus(0, 1, 0, 0, 32'h8, 8'hFF, 64'h1122334455667788, 1);
        collect(0);
        send(1, 3'b000, 32'h5, 64'hA5, 5'd22, 0, 2'b00, 3);
        bus(0, 1, 0, 0, 32'h0, 8'h20, 64'h0000A50000000000, 1);
        collect(0);
        send(0, 3'b011, 32'h4, 0, 5'd23, 0, 2'b01, 1);
        collect(0);

        // reset while waiting on the bus
        sel = 1'b0;
        @(negedge clk);
        send(0, 3'b010, 32'h80000040, 0, 5'd24, 0, 2'b00, -1);
        bus(0, 0, 0, 0, 32'h80000040, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", m_req_ready, 1);
        chk("mid_rst_resp_valid", m_resp_valid, 0);
        chk("mid_rst_bus_valid", m_bus_req_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("post_rst_req_ready", m_req_ready, 1);
        chk("post_rst_resp_valid", m_resp_valid, 0);

        // unit still works after the abandoned access
        send(0, 3'b100, 32'h80000001, 0, 5'd25, 64'h00000034, 2'b00, 3);
        bus(0, 1, 64'h12F03456, 0, 32'h80000000, 8'h00, 0, 0);
        collect(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
